ifu: RTL and testbench

Instruction fetch unit: holds the architectural PC, fetches one 32-bit instruction per PC from instruction memory over an AXI-lite read channel (AR/R), and presents the instruction and its PC to `idu` via a valid/ready handshake. Single-issue and non-speculative: after each handoff it waits for `idu` to return the next PC (`pc_next` / `pc_write_enable`) before fetching again. Sits directly upstream of `idu`; its outputs drive `instruction_input`, `pc_input` and `idu_receive_valid`.

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_if.sv | 34 +++
 rtl/ifu_perf.sv | 32 +++
 rtl/ifu.sv | 146 ++++++++++++++
 tb/tb_ifu.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   ifu_state_e  - fetch FSM state encoding (3-bit)
//   EBREAK_INST  - instruction substituted when a fetch returns an error response
//   RESP_OKAY    - AXI-lite OKAY response code
package ysyx_23060059_ifu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StResp,
    StSend,
    StWaitPc
  } ifu_state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;

endpackage

// File: rtl/ifu_if.sv
// AXI-lite read channel (AR/R) between the fetch unit and instruction memory.
//   master : fetch unit   - drives araddr, arvalid, rready
//   slave  : memory side  - drives arready, rdata, rresp, rvalid
interface ifu_if;

  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr,
    output arvalid,
    output rready,
    input  arready,
    input  rdata,
    input  rresp,
    input  rvalid
  );

  modport slave (
    input  araddr,
    input  arvalid,
    input  rready,
    output arready,
    output rdata,
    output rresp,
    output rvalid
  );

endinterface

// File: rtl/ifu_perf.sv
// Fetch performance counters.
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   fetch_i        - one instruction handed to the decoder this cycle
//   stall_i        - fetch unit is waiting on memory (request or response phase)
//   fetch_cnt_o    - number of handoffs, wraps at 2^32
//   stall_cnt_o    - number of memory-wait cycles, wraps at 2^32
module ifu_perf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_i,
  input  logic        stall_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fetch_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_i) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit. Holds the architectural PC, fetches one instruction per PC over an
// AXI-lite read channel and hands {instruction, pc} to the decoder over valid/ready. After each
// handoff it waits for the decoder to write back the next PC before fetching again.
//   clk_i, rst_ni         - clock, asynchronous active-low reset
//   pc_next_i             - next PC from the decoder
//   pc_write_enable_i     - pc_next_i is valid this cycle
//   ifu_receive_ready_i   - decoder accepts the instruction
//   ifu_send_valid_o      - instruction_o / pc_o valid
//   instruction_o, pc_o   - fetched instruction and its PC
//   fetch_err_o           - sticky, set on any non-OKAY read response
//   axi                   - AXI-lite read master (ifu_if.master)
// Optional (YSYX_23060059_IFU_PERF_EN defined):
//   perf_fetch_cnt_o      - handoff count
//   perf_stall_cnt_o      - cycles spent waiting on memory
module ifu
  import ysyx_23060059_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  pc_next_i,
  input  logic         pc_write_enable_i,
  input  logic         ifu_receive_ready_i,
  output logic         ifu_send_valid_o,
  output logic [31:0]  instruction_o,
  output logic [31:0]  pc_o,
  output logic         fetch_err_o,
  ifu_if.master        axi
`ifdef YSYX_23060059_IFU_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt_o,
  output logic [31:0]  perf_stall_cnt_o
`endif
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic [31:0] araddr_q;
  logic        arvalid_q;
  logic        rready_q;
  logic        err_q;

  // All outputs are registered and updated together with the state, so each output already
  // carries the value that belongs to the state being entered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      valid_q   <= 1'b0;
      araddr_q  <= RESET_PC;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q   <= StReq;
          araddr_q  <= pc_q;
          arvalid_q <= 1'b1;
        end
        StReq: begin
          if (arvalid_q && axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= StSend;
            if (axi.rresp != RESP_OKAY) begin
              err_q  <= 1'b1;
              inst_q <= EBREAK_INST;
            end else begin
              inst_q <= axi.rdata;
            end
          end
        end
        StSend: begin
          if (ifu_receive_ready_i) begin
            valid_q <= 1'b0;
            // A PC write-back coincident with the handshake skips WAIT_PC entirely.
            if (pc_write_enable_i) begin
              pc_q      <= pc_next_i;
              araddr_q  <= pc_next_i;
              arvalid_q <= 1'b1;
              state_q   <= StReq;
            end else begin
              state_q   <= StWaitPc;
            end
          end
        end
        StWaitPc: begin
          if (pc_write_enable_i) begin
            pc_q      <= pc_next_i;
            araddr_q  <= pc_next_i;
            arvalid_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ifu_send_valid_o = valid_q;
  assign instruction_o    = inst_q;
  assign pc_o             = pc_q;
  assign fetch_err_o      = err_q;
  assign axi.araddr       = araddr_q;
  assign axi.arvalid      = arvalid_q;
  assign axi.rready       = rready_q;

`ifdef YSYX_23060059_IFU_PERF_EN
  logic fetch_hs;
  logic mem_wait;

  assign fetch_hs = (state_q == StSend) && ifu_receive_ready_i;
  assign mem_wait = (state_q == StReq) || (state_q == StResp);

  ifu_perf u_perf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .fetch_i     (fetch_hs),
    .stall_i     (mem_wait),
    .fetch_cnt_o (perf_fetch_cnt_o),
    .stall_cnt_o (perf_stall_cnt_o)
  );
`endif

  // The decoder may only write back a PC once it has taken the current instruction.
  pc_we_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      pc_write_enable_i |->
        ((state_q == StWaitPc) || ((state_q == StSend) && ifu_receive_ready_i)));

  // Only one read is ever outstanding, so a response outside RESP means a broken memory.
  rvalid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      axi.rvalid |-> (state_q == StResp));

endmodule

// File: tb/tb_ifu.sv
module tb_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        pc_we;
  logic        rdy;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        fetch_err;
`ifdef YSYX_23060059_IFU_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  ifu_if bus ();

  ifu #(
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .pc_next_i           (pc_next),
    .pc_write_enable_i   (pc_we),
    .ifu_receive_ready_i (rdy),
    .ifu_send_valid_o    (valid),
    .instruction_o       (instr),
    .pc_o                (pc),
    .fetch_err_o         (fetch_err),
    .axi                 (bus)
`ifdef YSYX_23060059_IFU_PERF_EN
    ,
    .perf_fetch_cnt_o    (perf_fetch),
    .perf_stall_cnt_o    (perf_stall)
`endif
  );

  // ---------------- memory model ----------------
  int          ar_delay;
  int          r_delay;
  logic [1:0]  next_resp;
  int          ar_cnt;
  int          r_cnt;
  logic        r_busy;
  logic [31:0] r_addr;
  logic [1:0]  r_code;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RESET_PC) return 32'h0000_0013;
    return {a[15:0], 16'h0513};
  endfunction

  assign bus.arready = bus.arvalid && !r_busy && (ar_cnt >= ar_delay);
  assign bus.rvalid  = r_busy && (r_cnt >= r_delay);
  assign bus.rdata   = mem_word(r_addr);
  assign bus.rresp   = r_code;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_cnt <= 0;
      r_cnt  <= 0;
      r_busy <= 1'b0;
      r_addr <= '0;
      r_code <= '0;
    end else begin
      if (bus.arvalid && bus.arready) begin
        r_busy <= 1'b1;
        r_cnt  <= 0;
        r_addr <= bus.araddr;
        r_code <= next_resp;
        ar_cnt <= 0;
      end else if (bus.arvalid) begin
        ar_cnt <= ar_cnt + 1;
      end
      if (bus.rvalid && bus.rready) r_busy <= 1'b0;
      else if (r_busy && !bus.rvalid) r_cnt <= r_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int n_hand = 0;
  logic [63:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid && rdy) begin
      logic [63:0] e;
      n_hand++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_handoff", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("handoff_pc", {32'h0, pc}, {32'h0, e[63:32]});
        check_eq("handoff_inst", {32'h0, instr}, {32'h0, e[31:0]});
      end
    end
  end

  int cyc = 0;
  int rel_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rel_cycle();
    return cyc - rel_cyc + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return (next_resp != 2'b00) ? EBREAK : mem_word(a);
  endfunction

  // Waits (bounded) for ifu_send_valid, checking araddr whenever arvalid is up.
  task automatic wait_valid(input logic [31:0] exp_ar, output int at, output int first_ar);
    at = -1;
    first_ar = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.arvalid) begin
        if (first_ar < 0) first_ar = rel_cycle();
        check_eq("araddr_stable", {32'h0, bus.araddr}, {32'h0, exp_ar});
      end
      if (valid) begin
        at = rel_cycle();
        break;
      end
    end
    if (at < 0) check_eq("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic handoff();
    tick();
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  // Drives a one-cycle PC write-back and waits for the resulting instruction.
  task automatic fetch(input logic [31:0] a, input int extra, input string tag);
    int t, at, fa;
    pc_next = a;
    pc_we   = 1'b1;
    t       = rel_cycle();
    sb_q.push_back({a, exp_word(a)});
    tick();
    pc_we = 1'b0;
    wait_valid(a, at, fa);
    check_eq(tag, at, t + 3 + extra);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {63'h0, valid}, 64'd0);
    check_eq({tag, "_inst"}, {32'h0, instr}, 64'd0);
    check_eq({tag, "_pc"}, {32'h0, pc}, {32'h0, RESET_PC});
    check_eq({tag, "_araddr"}, {32'h0, bus.araddr}, {32'h0, RESET_PC});
    check_eq({tag, "_arvalid"}, {63'h0, bus.arvalid}, 64'd0);
    check_eq({tag, "_rready"}, {63'h0, bus.rready}, 64'd0);
    check_eq({tag, "_err"}, {63'h0, fetch_err}, 64'd0);
`ifdef YSYX_23060059_IFU_PERF_EN
    check_eq({tag, "_perf_fetch"}, {32'h0, perf_fetch}, 64'd0);
    check_eq({tag, "_perf_stall"}, {32'h0, perf_stall}, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, fa, c;
    logic [31:0] stall0;
    rst_n     = 1'b0;
    pc_next   = '0;
    pc_we     = 1'b0;
    rdy       = 1'b0;
    ar_delay  = 0;
    r_delay   = 0;
    next_resp = 2'b00;
    stall0    = '0;
    tick();
    tick();
    check_reset_outputs("reset");

    // First fetch after reset release, zero wait states.
    rst_n   = 1'b1;
    rel_cyc = cyc;
    sb_q.push_back({RESET_PC, 32'h0000_0013});
    wait_valid(RESET_PC, at, fa);
    check_eq("first_arvalid_cycle", fa, 2);
    check_eq("first_valid_cycle", at, 4);

    // Decoder stalls four cycles: outputs must hold.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("hold_valid", {63'h0, valid}, 64'd1);
      check_eq("hold_pc", {32'h0, pc}, {32'h0, RESET_PC});
      check_eq("hold_inst", {32'h0, instr}, 64'h13);
    end
    handoff();
    check_eq("one_handoff", n_hand, 1);
    check_eq("valid_dropped", {63'h0, valid}, 64'd0);
`ifdef YSYX_23060059_IFU_PERF_EN
    check_eq("perf_fetch_1", {32'h0, perf_fetch}, 64'd1);
`endif

    // PC write-back two cycles after the handshake.
    tick();
    fetch(32'h8000_0100, 0, "wb_late_latency");

    // PC write-back coincident with the handshake.
    c = rel_cycle();
    tick();
    rdy     = 1'b1;
    pc_we   = 1'b1;
    pc_next = 32'h8000_0200;
    sb_q.push_back({32'h8000_0200, mem_word(32'h8000_0200)});
    tick();
    rdy   = 1'b0;
    pc_we = 1'b0;
    check_eq("coinc_arvalid", {63'h0, bus.arvalid}, 64'd1);
    check_eq("coinc_araddr", {32'h0, bus.araddr}, 64'h8000_0200);
    check_eq("coinc_valid_low", {63'h0, valid}, 64'd0);
    wait_valid(32'h8000_0200, at, fa);
    check_eq("coinc_latency", at, c + 1 + 3);

    // Memory wait states: arready 3 late, rvalid 2 late.
    handoff();
    ar_delay = 3;
    r_delay  = 2;
`ifdef YSYX_23060059_IFU_PERF_EN
    stall0 = perf_stall;
`endif
    fetch(32'h8000_0300, 5, "wait_state_latency");
`ifdef YSYX_23060059_IFU_PERF_EN
    check_eq("perf_stall_delta", {32'h0, perf_stall - stall0}, 64'd7);
`endif

    // Error response, then a clean fetch: error stays sticky.
    handoff();
    ar_delay  = 0;
    r_delay   = 0;
    next_resp = 2'b10;
    fetch(32'h8000_0400, 0, "err_latency");
    check_eq("err_set", {63'h0, fetch_err}, 64'd1);
    check_eq("err_inst", {32'h0, instr}, {32'h0, EBREAK});
    handoff();
    next_resp = 2'b00;
    fetch(32'h8000_0500, 0, "ok_after_err_latency");
    check_eq("err_sticky", {63'h0, fetch_err}, 64'd1);
    handoff();
`ifdef YSYX_23060059_IFU_PERF_EN
    check_eq("perf_fetch_6", {32'h0, perf_fetch}, 64'd6);
`endif

    // Reset asserted while the read response is outstanding.
    r_delay = 5;
    pc_next = 32'h8000_0600;
    pc_we   = 1'b1;
    tick();
    pc_we = 1'b0;
    c = 0;
    for (int i = 0; i < 20 && c == 0; i++) begin
      @(negedge clk);
      if (bus.rready) c = 1;
    end
    check_eq("reached_resp", c, 1);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    r_delay = 0;
    tick();
    tick();
    rst_n   = 1'b1;
    rel_cyc = cyc;
    sb_q.push_back({RESET_PC, 32'h0000_0013});
    wait_valid(RESET_PC, at, fa);
    check_eq("restart_arvalid_cycle", fa, 2);
    check_eq("restart_valid_cycle", at, 4);
    handoff();

    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("total_handoffs", n_hand, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
